pll_reset_sequencer: RTL and testbench

- Controller at the opposite end of a PLL's rst/locked interface.
- Drives the PLL reset, waits for and qualifies the PLL lock indication, then releases the core reset to logic clocked by the PLL outputs.
- Detects loss of lock, re-sequences the PLL, retries on lock timeout and flags a fault after repeated failures.
- Sits beside the PLL wrapper in the core top level and runs on the 50 MHz board reference clock.

---
 rtl/pll_seq_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 34 +++
 rtl/pll_reset_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_seq_pkg
// Description : Shared types and constants for the PLL reset sequencer:
//               sequencer state encoding and retry counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

    // Sequencer states, explicitly encoded on 3 bits
    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } seq_state_e;

    // Width of the retry_count output (MAX_RETRIES is limited to 1..15)
    localparam int c_retry_w = 4;

endpackage : pll_seq_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for quasi-static asynchronous inputs.
//               Asynchronous active-low reset clears both stages to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // First stage may go metastable; second stage gives it a cycle to settle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Drives the PLL reset, qualifies the synchronised lock signal,
//               releases the core reset, re-sequences on loss of lock, retries
//               on lock timeout and flags a fault once retries are exhausted.
//               Optional macro PLL_SEQ_LOSS_COUNT_EN adds an 8-bit saturating
//               loss-of-lock counter output (loss_count).
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRIES  = 7
) (
    input  logic                 refclk,
    input  logic                 rst_n,
    input  logic                 pll_locked,
    input  logic                 force_relock,
    output logic                 pll_rst,
    output logic                 core_rst,
    output logic                 ready,
    output logic                 fault,
    output logic [c_retry_w-1:0] retry_count
`ifdef PLL_SEQ_LOSS_COUNT_EN
    ,
    output logic [7:0]           loss_count
`endif
);

    localparam int c_rst_w  = $clog2(RST_CYCLES + 1);
    localparam int c_to_w   = $clog2(LOCK_TIMEOUT + 1);
    localparam int c_stab_w = $clog2(LOCK_STABLE + 1);

    localparam logic [c_rst_w-1:0]   c_rst_last    = c_rst_w'(RST_CYCLES - 1);
    localparam logic [c_to_w-1:0]    c_to_last     = c_to_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_to_w-1:0]    c_to_max      = c_to_w'(LOCK_TIMEOUT);
    localparam logic [c_stab_w-1:0]  c_stab_last   = c_stab_w'(LOCK_STABLE - 1);
    localparam logic [c_retry_w-1:0] c_max_retries = c_retry_w'(MAX_RETRIES);

    seq_state_e           r_state,     w_state_nxt;
    logic [c_rst_w-1:0]   r_rst_cnt,   w_rst_cnt_nxt;
    logic [c_to_w-1:0]    r_to_cnt,    w_to_cnt_nxt;
    logic [c_stab_w-1:0]  r_stab_cnt,  w_stab_cnt_nxt;
    logic [c_retry_w-1:0] r_retry,     w_retry_nxt;

    logic r_pll_rst;
    logic r_core_rst;
    logic r_ready;
    logic r_fault;

    logic w_locked_s;
    logic w_timeout;
    logic [c_to_w-1:0] w_to_inc;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk     (refclk),
        .rst_n   (rst_n),
        .i_async (pll_locked),
        .o_sync  (w_locked_s)
    );

    // The timeout window is shared by WAIT_LOCK and STABLE; the counter holds
    // at its ceiling rather than wrapping
    assign w_timeout = (r_to_cnt >= c_to_last);
    assign w_to_inc  = (r_to_cnt == c_to_max) ? r_to_cnt : r_to_cnt + 1'b1;

    // Next-state and counter update; force_relock overrides every other event
    always_comb begin
        w_state_nxt    = r_state;
        w_rst_cnt_nxt  = r_rst_cnt;
        w_to_cnt_nxt   = r_to_cnt;
        w_stab_cnt_nxt = r_stab_cnt;
        w_retry_nxt    = r_retry;

        if (force_relock) begin
            w_state_nxt   = RESET_PLL;
            w_rst_cnt_nxt = '0;
            w_retry_nxt   = '0;
        end else begin
            case (r_state)
                RESET_PLL: begin
                    if (r_rst_cnt >= c_rst_last) begin
                        w_state_nxt  = WAIT_LOCK;
                        w_to_cnt_nxt = '0;
                    end else begin
                        w_rst_cnt_nxt = r_rst_cnt + 1'b1;
                    end
                end
                WAIT_LOCK, STABLE: begin
                    if (w_timeout) begin
                        if (r_retry < c_max_retries) begin
                            w_retry_nxt   = r_retry + 1'b1;
                            w_state_nxt   = RESET_PLL;
                            w_rst_cnt_nxt = '0;
                        end else begin
                            w_state_nxt = FAULT;
                        end
                    end else begin
                        w_to_cnt_nxt = w_to_inc;
                        if (r_state == WAIT_LOCK) begin
                            if (w_locked_s) begin
                                w_state_nxt    = STABLE;
                                w_stab_cnt_nxt = '0;
                            end
                        end else if (!w_locked_s) begin
                            w_state_nxt = WAIT_LOCK;
                        end else if (r_stab_cnt >= c_stab_last) begin
                            w_state_nxt = RUN;
                            w_retry_nxt = '0;
                        end else begin
                            w_stab_cnt_nxt = r_stab_cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!w_locked_s) begin
                        w_state_nxt   = RESET_PLL;
                        w_rst_cnt_nxt = '0;
                    end
                end
                FAULT: begin
                    w_state_nxt = FAULT;
                end
                default: begin
                    w_state_nxt   = RESET_PLL;
                    w_rst_cnt_nxt = '0;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RESET_PLL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencing counters and retry tally
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_cnt  <= '0;
            r_to_cnt   <= '0;
            r_stab_cnt <= '0;
            r_retry    <= '0;
        end else begin
            r_rst_cnt  <= w_rst_cnt_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
            r_stab_cnt <= w_stab_cnt_nxt;
            r_retry    <= w_retry_nxt;
        end
    end

    // Outputs decoded from the next state so they change on the same edge
    // as the state they describe
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_pll_rst  <= 1'b1;
            r_core_rst <= 1'b1;
            r_ready    <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_pll_rst  <= (w_state_nxt == RESET_PLL);
            r_core_rst <= (w_state_nxt != RUN);
            r_ready    <= (w_state_nxt == RUN);
            r_fault    <= (w_state_nxt == FAULT);
        end
    end

    assign pll_rst     = r_pll_rst;
    assign core_rst    = r_core_rst;
    assign ready       = r_ready;
    assign fault       = r_fault;
    assign retry_count = r_retry;

`ifdef PLL_SEQ_LOSS_COUNT_EN
    logic [7:0] r_loss_cnt;
    logic       w_loss_event;

    // Only a genuine loss of lock while running counts, not a forced relock
    assign w_loss_event = !force_relock && (r_state == RUN) && !w_locked_s;

    // Saturating loss-of-lock counter, cleared only by rst_n
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_loss_cnt <= '0;
        end else if (w_loss_event && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 1'b1;
        end
    end

    assign loss_count = r_loss_cnt;
`endif

endmodule : pll_reset_sequencer
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_sequencer
// Description : Self-checking bench for pll_reset_sequencer with
//               RST_CYCLES=4, LOCK_TIMEOUT=100, LOCK_STABLE=8, MAX_RETRIES=2.
//               Define PLL_SEQ_LOSS_COUNT_EN to also check loss_count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

    logic       refclk       = 1'b0;
    logic       rst_n        = 1'b0;
    logic       pll_locked   = 1'b0;
    logic       force_relock = 1'b0;
    logic       pll_rst;
    logic       core_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;
`ifdef PLL_SEQ_LOSS_COUNT_EN
    logic [7:0] loss_count;
`endif

    pll_reset_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (100),
        .LOCK_STABLE  (8),
        .MAX_RETRIES  (2)
    ) u_dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .force_relock (force_relock),
        .pll_rst      (pll_rst),
        .core_rst     (core_rst),
        .ready        (ready),
        .fault        (fault),
        .retry_count  (retry_count)
`ifdef PLL_SEQ_LOSS_COUNT_EN
        ,
        .loss_count   (loss_count)
`endif
    );

    always #5 refclk = ~refclk;

    // One row = n consecutive cycles with fixed inputs and fixed expected outputs
    typedef struct {
        int         n;
        logic       rstn;
        logic       lk;
        logic       fr;
        logic       pll;
        logic       core;
        logic       rdy;
        logic       flt;
        logic [3:0] rc;
        logic [7:0] loss;
    } row_t;

    typedef struct {
        logic       pll;
        logic       core;
        logic       rdy;
        logic       flt;
        logic [3:0] rc;
        logic [7:0] loss;
        int         step;
    } exp_t;

    row_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_no  = 0;

    function automatic row_t r(input int n, input logic rstn, input logic lk,
                               input logic fr, input logic pll, input logic core,
                               input logic rdy, input logic flt,
                               input logic [3:0] rc, input logic [7:0] loss);
        row_t x;
        x.n = n; x.rstn = rstn; x.lk = lk; x.fr = fr; x.pll = pll;
        x.core = core; x.rdy = rdy; x.flt = flt; x.rc = rc; x.loss = loss;
        return x;
    endfunction

    task automatic chk(input string name, input int step,
                       input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at step %0d: got %0h, expected %0h", name, step, act, exp);
        end
    endtask

    // Drive each row cycle by cycle, queueing what the outputs must show
    task automatic run_table();
        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                exp_t e;
                @(posedge refclk);
                #1;
                rst_n        = tbl[i].rstn;
                pll_locked   = tbl[i].lk;
                force_relock = tbl[i].fr;
                e.pll = tbl[i].pll; e.core = tbl[i].core; e.rdy = tbl[i].rdy;
                e.flt = tbl[i].flt; e.rc = tbl[i].rc; e.loss = tbl[i].loss;
                e.step = step_no;
                sb.push_back(e);
                step_no++;
            end
        end
        tbl.delete();
    endtask

    // Scoreboard: compare on the falling edge, away from the active edge
    always @(negedge refclk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pll_rst",     e.step, {7'd0, pll_rst},  {7'd0, e.pll});
            chk("core_rst",    e.step, {7'd0, core_rst}, {7'd0, e.core});
            chk("ready",       e.step, {7'd0, ready},    {7'd0, e.rdy});
            chk("fault",       e.step, {7'd0, fault},    {7'd0, e.flt});
            chk("retry_count", e.step, {4'd0, retry_count}, {4'd0, e.rc});
`ifdef PLL_SEQ_LOSS_COUNT_EN
            chk("loss_count",  e.step, loss_count, e.loss);
`endif
        end
    end

    initial begin
        // Reset, nominal lock, loss of lock, stable-window glitch
        tbl.push_back(r(3,  0, 0, 0, 1, 1, 0, 0, 0, 0));   // held in reset
        tbl.push_back(r(4,  1, 0, 0, 1, 1, 0, 0, 0, 0));   // 4-cycle pll_rst
        tbl.push_back(r(10, 1, 0, 0, 0, 1, 0, 0, 0, 0));   // waiting, no lock
        tbl.push_back(r(11, 1, 1, 0, 0, 1, 0, 0, 0, 0));   // lock raised: 11 cycles to ready
        tbl.push_back(r(3,  1, 1, 0, 0, 0, 1, 0, 0, 0));   // RUN
        tbl.push_back(r(3,  1, 0, 0, 0, 0, 1, 0, 0, 0));   // lock dropped: 3 cycles still RUN
        tbl.push_back(r(4,  1, 0, 0, 1, 1, 0, 0, 0, 1));   // new pll_rst pulse
        tbl.push_back(r(2,  1, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(r(5,  1, 1, 0, 0, 1, 0, 0, 0, 1));   // lock high 5 cycles
        tbl.push_back(r(3,  1, 0, 0, 0, 1, 0, 0, 0, 1));   // glitch low 3 cycles
        tbl.push_back(r(11, 1, 1, 0, 0, 1, 0, 0, 0, 1));   // stable count restarts
        tbl.push_back(r(3,  1, 1, 0, 0, 0, 1, 0, 0, 1));   // RUN again
        // Timeouts with lock held low, ending in FAULT
        tbl.push_back(r(2,   0, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(r(4,   1, 0, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(r(100, 1, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(r(4,   1, 0, 0, 1, 1, 0, 0, 1, 0));
        tbl.push_back(r(100, 1, 0, 0, 0, 1, 0, 0, 1, 0));
        tbl.push_back(r(4,   1, 0, 0, 1, 1, 0, 0, 2, 0));
        tbl.push_back(r(100, 1, 0, 0, 0, 1, 0, 0, 2, 0));
        tbl.push_back(r(5,   1, 0, 0, 0, 1, 0, 1, 2, 0));  // FAULT holds
        // Recovery from FAULT via a single force_relock pulse
        tbl.push_back(r(1, 1, 1, 1, 0, 1, 0, 1, 2, 0));
        tbl.push_back(r(4, 1, 1, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(r(9, 1, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(r(3, 1, 1, 0, 0, 0, 1, 0, 0, 0));
        // force_relock held 6 cycles from RUN: RESET_PLL count restarts each cycle
        tbl.push_back(r(1, 1, 1, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(r(5, 1, 1, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(r(4, 1, 1, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(r(9, 1, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(r(2, 1, 1, 0, 0, 0, 1, 0, 0, 0));
        // Walk into STABLE ahead of the mid-sequence reset
        tbl.push_back(r(1, 1, 1, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(r(4, 1, 1, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(r(4, 1, 1, 0, 0, 1, 0, 0, 0, 0));
        run_table();

        // Mid-sequence reset in STABLE: outputs must change without a clock edge
        @(posedge refclk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_pll_rst",  step_no, {7'd0, pll_rst},  8'd1);
        chk("async_core_rst", step_no, {7'd0, core_rst}, 8'd1);
        chk("async_ready",    step_no, {7'd0, ready},    8'd0);
        chk("async_fault",    step_no, {7'd0, fault},    8'd0);
        chk("async_retry",    step_no, {4'd0, retry_count}, 8'd0);
        step_no++;

        // Full sequence restarts after release
        tbl.push_back(r(1, 0, 1, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(r(4, 1, 1, 0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(r(9, 1, 1, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(r(3, 1, 1, 0, 0, 0, 1, 0, 0, 0));
        run_table();

        @(negedge refclk);
        @(negedge refclk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pll_reset_sequencer
`default_nettype wire
